rd_writeback: RTL
=================

// Module: rd_writeback
// PURPOSE
//  Writeback end of the operand path: takes finished results from execute,
//  decodes the opcode to decide whether rd is written, and commits to the
//  32x32 integer register file. Loads stall until memory returns data.
//  Two combinational read ports supply rs1/rs2 operand values
//  (rs1_data feeds the rs1 operand register's write_data_regfile input).
// PARAMETERS
//  DATA_W   32  register/result width (only 32 supported)
//  ADDR_W   5   register index width (2**ADDR_W registers)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  wb_valid     in   1       execute result valid
//  wb_ready     out  1       writeback can accept a result
//  wb_opcode    in   7       instruction opcode
//  wb_funct3    in   3       load size/sign select
//  wb_rd        in   5       destination register index
//  wb_result    in   32      ALU/link/immediate result
//  mem_rvalid   in   1       load data valid from data memory
//  mem_rdata    in   32      raw load word, already byte-aligned to bit 0
//  rs1_addr     in   5       read port 1 index
//  rs1_data     out  32      read port 1 data (combinational)
//  rs2_addr     in   5       read port 2 index
//  rs2_data     out  32      read port 2 data (combinational)
//  commit_valid out  1       registered pulse: a register was written
//  commit_rd    out  5       index written (valid with commit_valid)
//  commit_data  out  32      value written (valid with commit_valid)
// BEHAVIOUR
//  - Reset (async): state=IDLE, all registers=0, commit_*=0, wb_ready=1 after release.
//  - Writing opcodes, opcode[6:2]: 01100 R, 00100 I-ALU, 00000 LOAD, 01101 LUI,
//    00101 AUIPC, 11011 JAL, 11001 JALR. All others (store 01000, branch 11000,
//    system 11100, unknown) are accepted and dropped with no write.
//  - rd=0 never written; x0 always reads 0; commit_valid stays 0.
//  - FSM IDLE: wb_ready=1. Transfer = wb_valid & wb_ready at rising edge.
//      non-load writing op: reg[wb_rd] <= wb_result at that edge; stay IDLE.
//      LOAD: latch rd, funct3; -> LOAD_WAIT (even if rd=0).
//  - FSM LOAD_WAIT: wb_ready=0. On edge with mem_rvalid: write extended data,
//    -> IDLE (wb_ready=1 next cycle). Back-to-back loads: one per 2 cycles minimum.
//  - Load extension by latched funct3: 000 LB sext[7:0], 001 LH sext[15:0],
//    010 LW, 100 LBU zext[7:0], 101 LHU zext[15:0]; others -> raw word.
//  - mem_rvalid in IDLE ignored. wb_valid in LOAD_WAIT ignored (not consumed).
//  - commit_valid/rd/data register the write: asserted exactly 1 cycle after
//    the write edge, for one cycle; 0 when no write occurred.
//  - Read ports: rsN_data = (rsN_addr==0) ? 0 : reg[rsN_addr] (pre-edge value).
//  - Reset asserted in LOAD_WAIT: pending load discarded, FSM -> IDLE, no write.
// CONFIGURATION
//  WB_BYPASS_EN defined: a read port whose address equals the index being
//    written this cycle (non-zero) returns the value being written (wb_result
//    on IDLE transfer, extended mem_rdata on LOAD_WAIT completion).
//  WB_BYPASS_EN undefined: read ports return the stored value only; new value
//    visible the cycle after the write edge.
// TESTING
//  1 Reset, read x1..x31 -> all 0; wb_ready=1; commit_valid=0.
//  2 R-type opcode 0110011, rd=5, result=0xDEADBEEF -> next cycle rs1_addr=5
//    reads 0xDEADBEEF; commit_valid=1, commit_rd=5 for one cycle.
//  3 LOAD funct3=000 rd=7, mem_rvalid 3 cycles later with 0x00000080 ->
//    wb_ready=0 while waiting; x7=0xFFFFFF80; with funct3=100 x7=0x00000080.
//  4 Store 0100011 rd=9 and any op rd=0 result=0x1234 -> x9, x0 unchanged,
//    commit_valid stays 0.
//  5 Same-cycle write rd=3=0x55 and rs2_addr=3 -> rs2_data=0x55 with
//    WB_BYPASS_EN, old value (0) without; next cycle 0x55 either way.
//  6 Assert rst during LOAD_WAIT, then mem_rvalid -> no write, state IDLE,
//    wb_ready=1, all registers 0.

Source files
------------

// File: rtl/rd_writeback.sv
// rtl/rd_writeback.sv - writeback stage: opcode decode, load extension, 32x32 register file commit
//
// Takes finished results from execute, decides from the opcode whether rd is
// written, and commits into the integer register file. A load parks the FSM in
// LOAD_WAIT until data memory returns the word. The word is then size/sign
// extended according to the latched funct3 before it is written.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   - a read port whose index matches the register being written
//               this cycle returns the value being written.
//   undefined - read ports return the stored value only.
//
// Ports
//   clk, rst                    rising-edge clock, asynchronous active-high reset
//   wb_valid / wb_ready         result handshake from execute
//   wb_opcode, wb_funct3        instruction opcode, load size/sign select
//   wb_rd, wb_result            destination index, ALU/link/immediate result
//   mem_rvalid, mem_rdata       load data return (byte-aligned to bit 0)
//   rs1_addr/rs1_data           combinational read port 1
//   rs2_addr/rs2_data           combinational read port 2
//   commit_valid/rd/data        registered one-cycle pulse describing a write

module rd_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [6:0]        wb_opcode,
    input  logic [2:0]        wb_funct3,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    output logic              commit_valid,
    output logic [ADDR_W-1:0] commit_rd,
    output logic [DATA_W-1:0] commit_data
);

    localparam int NREG = 1 << ADDR_W;

    // opcode[6:2] groups
    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_I_ALU = 5'b00100;
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_LOAD_WAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic                wb_ready_q, wb_ready_d;
    logic [ADDR_W-1:0]   ld_rd_q, ld_rd_d;
    logic [2:0]          ld_funct3_q, ld_funct3_d;
    logic                commit_valid_q, commit_valid_d;
    logic [ADDR_W-1:0]   commit_rd_q, commit_rd_d;
    logic [DATA_W-1:0]   commit_data_q, commit_data_d;
    logic [DATA_W-1:0]   regs_q [NREG];

    // Register-file write port, resolved combinationally for this cycle
    logic                rf_we;
    logic [ADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;

    logic [4:0]          op_group;
    logic                op_is_load;
    logic                op_writes_rd;
    logic                xfer;

    // Only opcode[6:2] selects behaviour; the low bits are don't-care.
    logic                unused_opcode_lsbs;
    assign unused_opcode_lsbs = ^wb_opcode[1:0];

    // ------------------------------------------------------------------
    // Load extension by funct3
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] load_extend(input logic [2:0]        f3,
                                                      input logic [DATA_W-1:0] raw);
        logic [DATA_W-1:0] res;
        case (f3)
            3'b000:  res = {{(DATA_W-8){raw[7]}}, raw[7:0]};
            3'b001:  res = {{(DATA_W-16){raw[15]}}, raw[15:0]};
            3'b100:  res = {{(DATA_W-8){1'b0}}, raw[7:0]};
            3'b101:  res = {{(DATA_W-16){1'b0}}, raw[15:0]};
            default: res = raw; // LW and undefined sizes pass the raw word
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    always_comb begin
        op_group     = wb_opcode[6:2];
        op_is_load   = (op_group == OP_LOAD);
        op_writes_rd = 1'b0;
        case (op_group)
            OP_R, OP_I_ALU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: op_writes_rd = 1'b1;
            default:                                           op_writes_rd = 1'b0;
        endcase
    end

    // wb_ready_q is high exactly when the FSM sits in IDLE
    assign xfer = wb_valid & wb_ready_q;

    // ------------------------------------------------------------------
    // Next-state and write-port logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ld_rd_d     = ld_rd_q;
        ld_funct3_d = ld_funct3_q;
        rf_we       = 1'b0;
        rf_waddr    = wb_rd;
        rf_wdata    = wb_result;

        case (state_q)
            S_IDLE: begin
                // mem_rvalid is meaningless here and is ignored
                if (xfer) begin
                    if (op_is_load) begin
                        // Enter LOAD_WAIT even for rd=0 so the memory beat is consumed
                        ld_rd_d     = wb_rd;
                        ld_funct3_d = wb_funct3;
                        state_d     = S_LOAD_WAIT;
                    end else if (op_writes_rd && (wb_rd != '0)) begin
                        rf_we = 1'b1;
                    end
                end
            end
            S_LOAD_WAIT: begin
                // wb_valid is not consumed here: wb_ready is low
                if (mem_rvalid) begin
                    rf_waddr = ld_rd_q;
                    rf_wdata = load_extend(ld_funct3_q, mem_rdata);
                    rf_we    = (ld_rd_q != '0);
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wb_ready_d     = (state_d == S_IDLE);
        commit_valid_d = rf_we;
        commit_rd_d    = rf_we ? rf_waddr : '0;
        commit_data_d  = rf_we ? rf_wdata : '0;
    end

    // ------------------------------------------------------------------
    // Sequential state, commit pulse and register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wb_ready_q     <= 1'b1;
            ld_rd_q        <= '0;
            ld_funct3_q    <= '0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_data_q  <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            wb_ready_q     <= wb_ready_d;
            ld_rd_q        <= ld_rd_d;
            ld_funct3_q    <= ld_funct3_d;
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_data_q  <= commit_data_d;
            if (rf_we) begin
                regs_q[rf_waddr] <= rf_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports: x0 is hardwired to zero
    // ------------------------------------------------------------------
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = regs_q[rs1_addr];
`ifdef WB_BYPASS_EN
            if (rf_we && (rf_waddr == rs1_addr)) begin
                rs1_data = rf_wdata;
            end
`endif
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            rs2_data = regs_q[rs2_addr];
`ifdef WB_BYPASS_EN
            if (rf_we && (rf_waddr == rs2_addr)) begin
                rs2_data = rf_wdata;
            end
`endif
        end
    end

    assign wb_ready     = wb_ready_q;
    assign commit_valid = commit_valid_q;
    assign commit_rd    = commit_rd_q;
    assign commit_data  = commit_data_q;

endmodule
